// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : dmem_arbiter
// Purpose  : Zero-fills the single-port data memory after reset, then
//            arbitrates its port between the MEM stage and a DMA/debug port.
// Revision : 1.0 - initial release
// ============================================================================
module dmem_arbiter #(
   parameter int WIDTH        = 32,
   parameter int DEPTH        = 100,
   parameter int STARVE_LIMIT = 8
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             cpu_req,
   input  logic             cpu_we,
   input  logic [WIDTH-1:0] cpu_addr,
   input  logic [WIDTH-1:0] cpu_wdata,
   output logic [WIDTH-1:0] cpu_rdata,
   output logic             cpu_stall,
   input  logic             dma_valid,
   input  logic             dma_we,
   input  logic [WIDTH-1:0] dma_addr,
   input  logic [WIDTH-1:0] dma_wdata,
   output logic             dma_ready,
   output logic [WIDTH-1:0] dma_rdata,
   output logic             dma_rvalid,
   output logic [WIDTH-1:0] mem_A,
   output logic [WIDTH-1:0] mem_WD,
   output logic             mem_WE,
   input  logic [WIDTH-1:0] mem_RD,
   output logic             init_done
);

   localparam int               c_CW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int               c_SW       = $clog2(STARVE_LIMIT + 1);
   localparam logic [0:0]       c_ST_CLEAR = 1'b0;
   localparam logic [0:0]       c_ST_RUN   = 1'b1;
   localparam logic [WIDTH-1:0] c_DEPTH    = WIDTH'(DEPTH);
   localparam logic [c_CW-1:0]  c_LAST     = c_CW'(DEPTH - 1);
   localparam logic [c_SW-1:0]  c_LIMIT    = c_SW'(STARVE_LIMIT);

   logic [0:0]       r_state;
   logic [c_CW-1:0]  r_clr_cnt;
   logic [c_SW-1:0]  r_starve_cnt;
   logic             r_init_done;
   logic             r_dma_rvalid;
   logic [WIDTH-1:0] r_dma_rdata;

   logic w_clear, w_run, w_force, w_dma_gnt, w_cpu_gnt, w_cpu_in, w_dma_in;

   // Reset overrides the state so the port is quiet while RST is held.
   assign w_clear   = !RST && (r_state == c_ST_CLEAR);
   assign w_run     = !RST && (r_state == c_ST_RUN);
   assign w_force   = dma_valid && (r_starve_cnt == c_LIMIT);
   assign w_dma_gnt = w_run && dma_valid && (w_force || !cpu_req);
   assign w_cpu_gnt = w_run && cpu_req && !w_dma_gnt;
   assign w_cpu_in  = cpu_addr < c_DEPTH;
   assign w_dma_in  = dma_addr < c_DEPTH;

   always_comb begin
      mem_A     = '0;
      mem_WD    = '0;
      mem_WE    = 1'b0;
      cpu_stall = 1'b1;
      dma_ready = 1'b0;
      cpu_rdata = '0;
      if (w_clear) begin
         mem_A  = WIDTH'(r_clr_cnt);
         mem_WE = 1'b1;
      end else if (w_run) begin
         cpu_stall = cpu_req && !w_cpu_gnt;
         dma_ready = w_dma_gnt;
         if (w_dma_gnt) begin
            mem_A  = dma_addr;
            mem_WD = dma_wdata;
            mem_WE = dma_we && w_dma_in;
         end else if (w_cpu_gnt) begin
            mem_A     = cpu_addr;
            mem_WD    = cpu_wdata;
            mem_WE    = cpu_we && w_cpu_in;
            cpu_rdata = w_cpu_in ? mem_RD : '0;
         end
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         r_state      <= c_ST_CLEAR;
         r_clr_cnt    <= '0;
         r_init_done  <= 1'b0;
         r_starve_cnt <= '0;
         r_dma_rvalid <= 1'b0;
         r_dma_rdata  <= '0;
      end else begin
         if (r_state == c_ST_CLEAR) begin
            r_clr_cnt <= r_clr_cnt + 1'b1;
            if (r_clr_cnt == c_LAST) begin
               r_state     <= c_ST_RUN;
               r_init_done <= 1'b1;
               r_clr_cnt   <= '0;
            end
         end
         r_dma_rvalid <= w_dma_gnt && !dma_we;
         if (w_dma_gnt && !dma_we)
            r_dma_rdata <= w_dma_in ? mem_RD : '0;
         if (!dma_valid || w_dma_gnt)
            r_starve_cnt <= '0;
         else if (r_starve_cnt != c_LIMIT)
            r_starve_cnt <= r_starve_cnt + 1'b1;
      end
   end

   assign init_done  = r_init_done;
   assign dma_rvalid = r_dma_rvalid;
   assign dma_rdata  = r_dma_rdata;

endmodule
`default_nettype wire
